lif_cfg_sequencer: RTL
======================

Name: lif_cfg_sequencer

Overview:
- Controller in front of the LIF neuron `top`. Owns that neuron's serial configuration port (`set_vars`, `expd`, `w`, `t`), its reset, and its synapse inputs.
- Accepts a parallel configuration word set over a valid/ready handshake, optionally pulses the neuron reset, then shifts the three lanes out MSB-first while `set_vars` is high.
- After a guard gap it opens the synapse path, counts axon spikes, and runs until stopped or reconfigured.

Parameters:
- CFG_LEN, 19, bits per lane; equals the number of cycles `set_vars` is held high.
- RST_CYC, 2, cycles `neuron_rst` is held high in NRST; minimum 1.
- GAP_CYC, 2, idle cycles between the end of load and RUN; 0 is legal.
- CNT_W, 16, width of the spike counter.

Ports:
- clk  in  1  system clock; all logic acts on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- cfg_valid  in  1  configuration request.
- cfg_ready  out  1  configuration can be accepted.
- cfg_exp  in  CFG_LEN  expd lane word.
- cfg_wgt  in  CFG_LEN  w lane word.
- cfg_thr  in  CFG_LEN  t lane word.
- cfg_rst_neuron  in  1  1 = run the NRST phase before LOAD; sampled on accept.
- stop  in  1  leave RUN.
- syn_in  in  4  synapse requests from upstream.
- axon  in  1  neuron spike output.
- neuron_rst  out  1  active-high reset to the neuron.
- set_vars  out  1  neuron configuration enable.
- expd  out  1  expd serial lane.
- w  out  1  w serial lane.
- t  out  1  t serial lane.
- syn  out  4  gated synapse drive to the neuron.
- busy  out  1  high in NRST, LOAD and GAP.
- running  out  1  high in RUN.
- frame_done  out  1  one-cycle pulse.
- spike_cnt  out  CNT_W  spikes counted in RUN.

Behaviour:
- All outputs are registered except `cfg_ready`.
- `cfg_ready` = rst_n & (state==IDLE | state==RUN).
- Reset (rst_n=0 at an edge):
  - state becomes IDLE.
  - Every registered output becomes 0: neuron_rst, set_vars, expd, w, t, syn, busy, running, frame_done, spike_cnt.
  - Shift registers and counters are cleared.
  - Reset mid-frame aborts the frame immediately; set_vars is 0 from the next cycle.
- Accept happens when cfg_valid & cfg_ready are both high at an edge:
  - The three lane words and cfg_rst_neuron are latched.
  - spike_cnt is cleared to 0.
  - Next state is NRST if cfg_rst_neuron=1, else LOAD.
  - Lane inputs are ignored after accept until the next accept.
- States:
  - IDLE: all drives 0. Transitions only on accept.
  - NRST: neuron_rst=1 for exactly RST_CYC cycles, then LOAD.
  - LOAD: exactly CFG_LEN cycles with set_vars=1.
    - In LOAD cycle k (k=0..CFG_LEN-1): expd=cfg_exp[CFG_LEN-1-k], w=cfg_wgt[CFG_LEN-1-k], t=cfg_thr[CFG_LEN-1-k].
    - Then GAP (or RUN directly if GAP_CYC=0).
  - GAP: GAP_CYC cycles with set_vars, lanes and syn all 0, then RUN.
  - RUN:
    - syn = syn_in delayed by one register (latency 1 cycle).
    - spike_cnt increments on each axon 0→1 transition, detected against a registered copy of axon. The registered copy is reset to 0 on entry to RUN.
    - spike_cnt saturates at 2^CNT_W-1.
    - stop=1 → IDLE next cycle; syn becomes 0 at that edge.
    - spike_cnt holds its value in IDLE.
- syn is 0 in every state except RUN.
- The lanes are 0 whenever set_vars=0.
- frame_done is high for the single cycle immediately after the last LOAD cycle (first GAP cycle or first RUN cycle).
- busy is 1 exactly in NRST, LOAD and GAP; running is 1 exactly in RUN.
- Simultaneous stop and accept in RUN: accept wins and the next state is NRST/LOAD, not IDLE.
- stop outside RUN is ignored.
- cfg_valid while busy is not accepted (cfg_ready=0); the request waits.
- A spike arriving on the same edge as an accept is not counted; the clear wins.
- Latency from accept edge to first set_vars=1 cycle: 1+RST_CYC cycles with cfg_rst_neuron=1, 1 cycle without.
- Frame length in cycles = RST_CYC (if enabled) + CFG_LEN + GAP_CYC.

Test Plan:
1. Reset check: rst_n=0 for 2 cycles with cfg_valid=1 → all outputs 0, no accept. First cycle after release: cfg_ready=1, state IDLE.
2. Full load with defaults: accept with cfg_exp=19'h7FF00, cfg_wgt=19'h7FFFF, cfg_thr=19'h40001, cfg_rst_neuron=1.
   - neuron_rst=1 for 2 cycles, then set_vars=1 for exactly 19 cycles.
   - w=1 throughout; expd shows 1 for 11 cycles then 0 for 8; t shows 1,0×17,1.
   - Then 2 gap cycles, frame_done pulse on the first gap cycle, running=1 after the gap.
3. Skip neuron reset: cfg_rst_neuron=0 → set_vars rises 1 cycle after accept, neuron_rst stays 0.
4. RUN gating and counting: syn_in=4'b1111 during LOAD → syn stays 0. In RUN, syn=4'b1111 one cycle after syn_in. Five axon pulses (axon held high 3 cycles each) → spike_cnt=5.
5. Reconfigure vs stop: in RUN with spike_cnt=5, assert stop and cfg_valid on the same edge → busy=1 next cycle, spike_cnt=0, syn=0. A later stop alone in RUN → IDLE, spike_cnt held.
6. Reset mid-LOAD: deassert rst_n at LOAD cycle 7 → set_vars=0 next cycle, state IDLE, lanes 0, no frame_done pulse.

Source files
------------

// File: rtl/lif_cfg_sequencer_if.sv
// Configuration handshake bundle for lif_cfg_sequencer: parallel lane words over valid/ready.
// No storage here; ready is driven combinationally by the slave.
interface lif_cfg_sequencer_if #(
   parameter int CFG_LEN = 19
);
   logic               cfg_valid;
   logic               cfg_ready;
   logic [CFG_LEN-1:0] cfg_exp;
   logic [CFG_LEN-1:0] cfg_wgt;
   logic [CFG_LEN-1:0] cfg_thr;
   logic               cfg_rst_neuron;

   modport master (
      output cfg_valid, cfg_exp, cfg_wgt, cfg_thr, cfg_rst_neuron,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid, cfg_exp, cfg_wgt, cfg_thr, cfg_rst_neuron,
      output cfg_ready
   );
endinterface

// File: rtl/lif_cfg_sequencer.sv
// Drives the LIF neuron: optional reset pulse, MSB-first serial load, guard gap, then gated RUN with spike count.
// Outputs registered (1-cycle latency); cfg_ready low while busy, so a request waits until IDLE or RUN.
module lif_cfg_sequencer #(
   parameter int CFG_LEN = 19,
   parameter int RST_CYC = 2,
   parameter int GAP_CYC = 2,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   lif_cfg_sequencer_if.slave    cfg,
   input  logic                  stop,
   input  logic [3:0]            syn_in,
   input  logic                  axon,
   output logic                  neuron_rst,
   output logic                  set_vars,
   output logic                  expd,
   output logic                  w,
   output logic                  t,
   output logic [3:0]            syn,
   output logic                  busy,
   output logic                  running,
   output logic                  frame_done,
   output logic [CNT_W-1:0]      spike_cnt
);
   localparam int PH_MAX = (CFG_LEN > RST_CYC) ? ((CFG_LEN > GAP_CYC) ? CFG_LEN : GAP_CYC)
                                               : ((RST_CYC > GAP_CYC) ? RST_CYC : GAP_CYC);
   localparam int PH_W = $clog2(PH_MAX + 1);

   typedef enum logic [2:0] {IDLE, NRST, LOAD, GAP, RUN} state_t;

   state_t             state, state_nxt;
   logic [PH_W-1:0]    ph;
   logic [CFG_LEN-1:0] sh_exp, sh_wgt, sh_thr;
   logic [CFG_LEN-1:0] src_exp, src_wgt, src_thr;
   logic               axon_q;
   logic               accept;

   assign cfg.cfg_ready = rst_n & ((state == IDLE) | (state == RUN));
   assign accept        = cfg.cfg_valid & cfg.cfg_ready;

   // On a direct IDLE/RUN -> LOAD accept the first bit must come straight from the input word.
   assign src_exp = accept ? cfg.cfg_exp : sh_exp;
   assign src_wgt = accept ? cfg.cfg_wgt : sh_wgt;
   assign src_thr = accept ? cfg.cfg_thr : sh_thr;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = cfg.cfg_rst_neuron ? NRST : LOAD;
         NRST: if (ph == PH_W'(RST_CYC - 1)) state_nxt = LOAD;
         LOAD: if (ph == PH_W'(CFG_LEN - 1)) state_nxt = (GAP_CYC == 0) ? RUN : GAP;
         GAP:  if (ph == PH_W'(GAP_CYC - 1)) state_nxt = RUN;
         RUN: begin
            if (accept)    state_nxt = cfg.cfg_rst_neuron ? NRST : LOAD;
            else if (stop) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         ph         <= '0;
         sh_exp     <= '0;
         sh_wgt     <= '0;
         sh_thr     <= '0;
         axon_q     <= 1'b0;
         neuron_rst <= 1'b0;
         set_vars   <= 1'b0;
         expd       <= 1'b0;
         w          <= 1'b0;
         t          <= 1'b0;
         syn        <= '0;
         busy       <= 1'b0;
         running    <= 1'b0;
         frame_done <= 1'b0;
         spike_cnt  <= '0;
      end else begin
         state <= state_nxt;
         ph    <= (state_nxt != state) ? '0 : ph + 1'b1;

         if (state_nxt == LOAD) begin
            expd   <= src_exp[CFG_LEN-1];
            w      <= src_wgt[CFG_LEN-1];
            t      <= src_thr[CFG_LEN-1];
            sh_exp <= {src_exp[CFG_LEN-2:0], 1'b0};
            sh_wgt <= {src_wgt[CFG_LEN-2:0], 1'b0};
            sh_thr <= {src_thr[CFG_LEN-2:0], 1'b0};
         end else begin
            expd <= 1'b0;
            w    <= 1'b0;
            t    <= 1'b0;
            if (accept) begin
               sh_exp <= cfg.cfg_exp;
               sh_wgt <= cfg.cfg_wgt;
               sh_thr <= cfg.cfg_thr;
            end
         end

         neuron_rst <= (state_nxt == NRST);
         set_vars   <= (state_nxt == LOAD);
         busy       <= (state_nxt == NRST) | (state_nxt == LOAD) | (state_nxt == GAP);
         running    <= (state_nxt == RUN);
         frame_done <= (state == LOAD) & (state_nxt != LOAD);
         syn        <= (state_nxt == RUN) ? syn_in : 4'b0000;

         // Edge detector history is zero on the first RUN cycle, so a high axon there counts.
         axon_q <= ((state == RUN) & (state_nxt == RUN)) ? axon : 1'b0;

         if (accept)
            spike_cnt <= '0;
         else if ((state == RUN) & axon & ~axon_q & (spike_cnt != {CNT_W{1'b1}}))
            spike_cnt <= spike_cnt + 1'b1;
      end
   end
endmodule
